// File: rtl/fifo_wr_frontend.sv
// fifo_wr_frontend: write-side front end of an async FIFO; skid buffer, read-pointer sync, optional fill level
//
// Ports:
//   reset              async active-high reset
//   wr_clk             write-domain clock
//   in_access          upstream packet valid
//   in_packet          upstream packet (DW bits)
//   in_wait            backpressure to upstream
//   rd_gray_pointer    read gray pointer from the read domain (async to wr_clk)
//   wr_gray_pointer    current write gray pointer
//   wr_fifo_full       registered FIFO full flag
//   wr_rd_gray_pointer read gray pointer after two-flop sync
//   wr_write           FIFO write strobe
//   wr_data            FIFO write data (zero when skid buffer empty)
//   wr_level           FIFO fill level (zero unless FIFO_WR_LEVEL_EN)
//   wr_almost_full     fill level at or above 2^AW - AF_MARGIN (zero unless FIFO_WR_LEVEL_EN)
//
// Define FIFO_WR_LEVEL_EN to build the fill-level tracker and let almost-full throttle upstream.
module fifo_wr_frontend #(
    parameter int AW        = 2,
    parameter int DW        = 104,
    parameter int AF_MARGIN = 1
) (
    input  logic          reset,
    input  logic          wr_clk,
    input  logic          in_access,
    input  logic [DW-1:0] in_packet,
    output logic          in_wait,
    input  logic [AW:0]   rd_gray_pointer,
    input  logic [AW:0]   wr_gray_pointer,
    input  logic          wr_fifo_full,
    output logic [AW:0]   wr_rd_gray_pointer,
    output logic          wr_write,
    output logic [DW-1:0] wr_data,
    output logic [AW:0]   wr_level,
    output logic          wr_almost_full
);
    logic [AW:0]   rd_sync1;
    logic [1:0]    count;
    logic [DW-1:0] ent0, ent1;
    logic          push, pop;

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            rd_sync1           <= '0;
            wr_rd_gray_pointer <= '0;
        end else begin
            rd_sync1           <= rd_gray_pointer;
            wr_rd_gray_pointer <= rd_sync1;
        end
    end

    // in_wait depends only on registers, so upstream never sees a combinational path from wr_fifo_full
    assign in_wait  = (count == 2'd2) | wr_almost_full;
    assign pop      = (count != 2'd0) & ~wr_fifo_full;
    assign push     = in_access & ~in_wait;
    assign wr_write = pop;
    assign wr_data  = (count != 2'd0) ? ent0 : '0;

    // ent0 is always the head; a push never coincides with count==2 because in_wait is high then
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            ent0  <= '0;
            ent1  <= '0;
        end else begin
            count <= count + 2'(push) - 2'(pop);
            if (pop && count == 2'd2)
                ent0 <= ent1;
            else if (push && (count == 2'd0 || (pop && count == 2'd1)))
                ent0 <= in_packet;
            if (push && !pop && count == 2'd1)
                ent1 <= in_packet;
        end
    end

`ifdef FIFO_WR_LEVEL_EN
    localparam logic [AW:0] AF_TH = (AW+1)'(2**AW - AF_MARGIN);

    function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // modulo-2^(AW+1) subtraction handles pointer wrap-around naturally
    logic [AW:0] wr_level_next;
    assign wr_level_next = gray2bin(wr_gray_pointer) - gray2bin(wr_rd_gray_pointer);

    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            wr_level       <= '0;
            wr_almost_full <= 1'b0;
        end else begin
            wr_level       <= wr_level_next;
            wr_almost_full <= (wr_level_next >= AF_TH);
        end
    end
`else
    logic unused_wr_gray;
    assign unused_wr_gray = ^wr_gray_pointer;
    assign wr_level       = '0;
    assign wr_almost_full = 1'b0;
`endif

endmodule
